// File: rtl/bcg_vram_writer.sv
// bcg_vram_writer: queues background-RAM write commands in a small FIFO and
// plays them out as single-byte writes, gated by the blanking write window.
module bcg_vram_writer #(
    parameter int DEPTH  = 4,
    parameter int STRIDE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [12:0] cmd_data,
    input  logic        wr_allow,
    output logic        we,
    output logic [12:0] waddr,
    output logic [7:0]  wdata,
    output logic        busy
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [12:0] STEP = 13'(STRIDE);

    localparam logic [1:0] OP_SETADDR = 2'd0;
    localparam logic [1:0] OP_WRITE   = 2'd1;
    localparam logic [1:0] OP_SETVAL  = 2'd2;
    localparam logic [1:0] OP_FILL    = 2'd3;

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t state, state_nxt;

    // command FIFO: {op, data} per entry
    logic [14:0]   mem [DEPTH];
    logic [AW-1:0] rd_idx, wr_idx;
    logic [AW:0]   count;
    logic          push, pop;
    logic [1:0]    head_op;
    logic [12:0]   head_data;

    // execution datapath
    logic [12:0] ptr, cnt;
    logic [7:0]  val;
    logic        issue, ld_ptr, ld_val, ld_cnt;
    logic [7:0]  issue_data;

    // ready depends on the registered count only, so a same-cycle pop never
    // opens a slot early
    assign cmd_ready = (count < FULL);
    assign push      = cmd_valid & cmd_ready;
    assign head_op   = mem[rd_idx][14:13];
    assign head_data = mem[rd_idx][12:0];
    assign busy      = (count != '0) | (state == FILL) | we;

    // FIFO storage: contents need no reset, count alone defines validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= {cmd_op, cmd_data};
    end

    // FIFO indices and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
        end else begin
            if (push) wr_idx <= wr_idx + 1'b1;
            if (pop)  rd_idx <= rd_idx + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // next-state: FILL entered on pop of a FILL, left on the cnt==0 write
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (count != '0 && head_op == OP_FILL) state_nxt = FILL;
            FILL: if (wr_allow && cnt == '0)             state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: pop/load/issue controls; FIFO is frozen while filling
    always_comb begin
        pop        = 1'b0;
        issue      = 1'b0;
        ld_ptr     = 1'b0;
        ld_val     = 1'b0;
        ld_cnt     = 1'b0;
        issue_data = val;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    case (head_op)
                        OP_SETADDR: begin pop = 1'b1; ld_ptr = 1'b1; end
                        OP_SETVAL:  begin pop = 1'b1; ld_val = 1'b1; end
                        OP_WRITE: begin
                            if (wr_allow) begin
                                pop        = 1'b1;
                                issue      = 1'b1;
                                issue_data = head_data[7:0];
                            end
                        end
                        default:    begin pop = 1'b1; ld_cnt = 1'b1; end
                    endcase
                end
            end
            FILL:    issue = wr_allow;
            default: issue = 1'b0;
        endcase
    end

    // pointer, fill value, fill counter and the registered write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= '0;
            val   <= '0;
            cnt   <= '0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            if (ld_ptr)     ptr <= head_data;
            else if (issue) ptr <= ptr + STEP;
            if (ld_val) val <= head_data[7:0];
            if (ld_cnt)                          cnt <= head_data;
            else if (state == FILL && issue)     cnt <= cnt - 1'b1;
            we <= issue;
            if (issue) begin
                waddr <= ptr;
                wdata <= issue_data;
            end
        end
    end

endmodule

// File: tb/tb_bcg_vram_writer.sv
// tb_bcg_vram_writer: scoreboard bench; expected writes are queued when the
// commands are sent and checked as the write strobe appears.
module tb_bcg_vram_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [12:0] cmd_data;
    logic        wr_allow;
    logic        we;
    logic [12:0] waddr;
    logic [7:0]  wdata;
    logic        busy;

    bcg_vram_writer #(.DEPTH(4), .STRIDE(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .wr_allow(wr_allow),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          pulses = 0;
    logic [20:0] sb [$];
    logic [12:0] m_ptr = '0;
    logic [7:0]  m_val = '0;
    logic        allow_q = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // window state seen at each edge; a strobe must follow an open window
    always @(posedge clk) allow_q <= wr_allow;

    // write monitor: every strobe is checked against the scoreboard head
    always @(negedge clk) begin
        if (rst && we) begin
            logic [20:0] e;
            pulses++;
            chk("we_in_window", 32'(allow_q), 32'd1);
            if (sb.size() == 0) chk("spurious_we", 32'(we), 32'd0);
            else begin
                e = sb.pop_front();
                chk("waddr", 32'(waddr), 32'(e[20:8]));
                chk("wdata", 32'(wdata), 32'(e[7:0]));
            end
        end
    end

    // send one command; caller sits #1 after a rising edge
    task automatic send(input logic [1:0] op, input logic [12:0] d);
        int n = 0;
        cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
        while (!cmd_ready && n < 2000) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        case (op)
            2'd0: m_ptr = d;
            2'd1: begin sb.push_back({m_ptr, d[7:0]}); m_ptr = m_ptr + 13'd1; end
            2'd2: m_val = d[7:0];
            default: for (int i = 0; i <= int'(d); i++) begin
                sb.push_back({m_ptr, m_val}); m_ptr = m_ptr + 13'd1;
            end
        endcase
    endtask

    // run until all expected writes are seen and the block is idle
    task automatic drain(input bit toggle);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 5000) begin
            @(posedge clk); #1;
            if (toggle) wr_allow = ~wr_allow;
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int p0, n;
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; wr_allow = 1'b0;
        #1;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        // two plain writes
        wr_allow = 1'b1;
        send(2'd0, 13'h1000);
        send(2'd1, 13'h0A5);
        send(2'd1, 13'h03C);
        drain(1'b0);

        // fill across the 8K wrap
        send(2'd0, 13'h1FFE);
        send(2'd2, 13'h077);
        send(2'd3, 13'd3);
        drain(1'b0);

        // back-pressure with the window closed
        wr_allow = 1'b0;
        send(2'd0, 13'h0100);
        for (int i = 0; i < 4; i++) send(2'd1, 13'(8'h10 + i));
        chk("full_ready", 32'(cmd_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("closed_no_we", 32'(we), 32'd0);
        wr_allow = 1'b1;
        send(2'd1, 13'h0F5);
        drain(1'b0);

        // SETVAL queued behind a FILL must not affect it
        wr_allow = 1'b0;
        send(2'd0, 13'h0200);
        send(2'd2, 13'h011);
        send(2'd3, 13'd2);
        send(2'd2, 13'h022);
        send(2'd3, 13'd0);
        wr_allow = 1'b1;
        drain(1'b0);

        // fill with a window that opens every other cycle
        send(2'd0, 13'h0300);
        send(2'd2, 13'h0C3);
        p0 = pulses;
        send(2'd3, 13'd9);
        drain(1'b1);
        chk("fill9_pulses", 32'(pulses - p0), 32'd10);

        // reset in the middle of a fill
        wr_allow = 1'b1;
        send(2'd0, 13'h0400);
        send(2'd2, 13'h05A);
        p0 = pulses;
        send(2'd3, 13'd7);
        n = 0;
        while (pulses - p0 < 3 && n < 200) begin @(negedge clk); n++; end
        chk("fill_started", 32'(pulses - p0 >= 3), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("abort_we", 32'(we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        sb.delete(); m_ptr = '0; m_val = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        p0 = pulses;
        repeat (12) @(posedge clk);
        #1 chk("no_write_after_abort", 32'(pulses - p0), 32'd0);
        send(2'd0, 13'h0800);
        send(2'd1, 13'h001);
        drain(1'b0);
        chk("post_rst_pulses", 32'(pulses - p0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcg_vram_writer.md
BCG_VRAM_WRITER -- requirements
Module: bcg_vram_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter STRIDE, default 1, meaning 13-bit pointer increment after every byte write.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  FIFO can accept a command.
REQ-007 SHALL have port cmd_op  input  2  opcode: 0 SETADDR, 1 WRITE, 2 SETVAL, 3 FILL.
REQ-008 SHALL have port cmd_data  input  13  operand: address (SETADDR), byte in [7:0] (WRITE, SETVAL), count-1 (FILL).
REQ-009 SHALL have port wr_allow  input  1  write window open (blanking); gates all RAM writes.
REQ-010 SHALL have port we  output  1  background RAM write strobe, one byte per cycle.
REQ-011 SHALL have port waddr  output  13  background RAM write address (same 8K x 8 map the background fetcher reads).
REQ-012 SHALL have port wdata  output  8  background RAM write data.
REQ-013 SHALL have port busy  output  1  FIFO non-empty, fill in progress, or write strobe active.

Function
REQ-014 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both 1; a command with cmd_ready 0 is not taken.
REQ-015 SHALL drive cmd_ready = (FIFO count < DEPTH), from registered count only; a pop in the same cycle does not raise cmd_ready.
REQ-016 SHALL execute commands strictly in acceptance order, at most one FIFO pop per cycle.
REQ-017 SHALL implement FSM states IDLE and FILL; reset state IDLE.
REQ-018 In IDLE with FIFO non-empty: SETADDR pops and loads ptr <= cmd_data; SETVAL pops and loads val <= cmd_data[7:0]; neither waits for wr_allow.
REQ-019 In IDLE, a WRITE at FIFO head SHALL pop only in a cycle with wr_allow 1; the next cycle we=1, waddr=ptr, wdata=cmd_data[7:0], and ptr <= ptr+STRIDE.
REQ-020 In IDLE, a FILL at FIFO head SHALL pop without waiting for wr_allow, load cnt <= cmd_data, and enter FILL.
REQ-021 In FILL, each cycle with wr_allow 1 SHALL issue one write of val at ptr (we the following cycle), ptr += STRIDE, cnt -= 1; the write made with cnt==0 returns to IDLE; total writes = cmd_data+1 (max 8192).
REQ-022 In FILL, cycles with wr_allow 0 SHALL issue no write and hold ptr, cnt, and state.
REQ-023 ptr arithmetic SHALL be 13-bit modulo 8192; 0x1FFF + 1 wraps to 0x0000 with no flag.
REQ-024 we, waddr, wdata SHALL be registered; we is 1 for exactly one cycle per byte; waddr and wdata hold their last values when we is 0.
REQ-025 No FIFO pop SHALL occur while in FILL; commands still accumulate until full.
REQ-026 A FILL of val then SETVAL queued behind it SHALL use the old val for every fill byte.
REQ-027 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave count unchanged with no data loss; a push to an empty FIFO may pop no earlier than the next cycle.

Reset
REQ-028 rst low SHALL asynchronously clear FIFO (count 0), ptr 0, val 0, cnt 0, state IDLE, we 0, waddr 0, wdata 0, busy 0; cmd_ready is 1 one cycle after rst rises.
REQ-029 Reset during FILL SHALL abort it; no further writes occur and the FIFO contents are discarded.

Verification
REQ-030 SETADDR 0x1000, WRITE 0xA5, WRITE 0x3C with wr_allow=1 -> we pulses: (0x1000,0xA5), (0x1001,0x3C); busy falls after the last pulse.
REQ-031 SETADDR 0x1FFE, SETVAL 0x77, FILL 3 (4 bytes) -> writes of 0x77 at 0x1FFE, 0x1FFF, 0x0000, 0x0001.
REQ-032 With wr_allow=0, push 5 WRITEs (DEPTH 4) -> cmd_ready 0 after 4; no we; raise wr_allow -> 4 writes in order, then 5th accepted and written.
REQ-033 FILL 9 with wr_allow toggling 1/0 each cycle -> exactly 10 we pulses, consecutive addresses, none in wr_allow=0 cycles.
REQ-034 rst low during FILL at write 3 of 8 -> we 0 immediately, no further writes after release; new SETADDR 0x0800, WRITE 0x01 -> single write (0x0800,0x01).
